// File: rtl/vga_channel_scheduler.sv
`timescale 1ns/1ps
// ============================================================================
// vga_channel_scheduler
//
// Sequences the voltage acquisition path that feeds the VGA overlay.
// The XADC DRP port is read round-robin over CHANNELS channels, one read per
// channel. Each 12-bit result is collected in a shadow bank. The complete
// shadow bank is copied to the display bank only on a rising edge of vertical
// blanking, and only after a full sweep has finished. This keeps the
// vga_draw_* modules from ever drawing a half-updated set of values.
//
// Optional build macro:
//   VGA_SCHED_AVG_EN - when defined, each new sample is averaged into the
//                      shadow entry as (old + new + 1) >> 1.
//                      Timeouts still write 12'hFFF directly.
//
// Ports:
//   clk          system clock, same domain as the VGA pipeline
//   rst          synchronous, active-high reset
//   enable       sweep runs while high. When it drops, the current
//                transaction finishes and the FSM then idles.
//   vblnk_in     vertical blank from the VGA bus
//   drp_den      DRP enable, one-cycle pulse per read
//   drp_dwe      DRP write enable, tied low
//   drp_daddr    DRP address, BASE_ADDR + channel index
//   drp_drdy     DRP data ready
//   drp_do       DRP read data; the result is drp_do[15:4]
//   disp_bank    published values; channel n is at [12n+11:12n]
//   frame_update one-cycle pulse in the cycle disp_bank changes
//   timeout_err  sticky per-channel timeout flags, cleared only by rst
//   sweep_done   one-cycle pulse after the last channel is stored
// ============================================================================
module vga_channel_scheduler #(
  parameter int         CHANNELS  = 13,
  parameter logic [6:0] BASE_ADDR = 7'h10,
  parameter int         TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     vblnk_in,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [6:0]               drp_daddr,
  input  logic                     drp_drdy,
  input  logic [15:0]              drp_do,
  output logic [12*CHANNELS-1:0]   disp_bank,
  output logic                     frame_update,
  output logic [CHANNELS-1:0]      timeout_err,
  output logic                     sweep_done
);

  localparam int DATA_W = 12;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_VAL  = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE,
    NEXT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pending;
  logic              vblnk_p0;
  logic              vblnk_p1;
  logic              publish;
  logic              sweep_last;
  logic [DATA_W-1:0] sample_p0;
  logic [DATA_W-1:0] store_val;
  logic [DATA_W-1:0] shadow [CHANNELS];

  // The low nibble of the DRP word carries no measurement.
  logic              unused_lsbs;
  assign unused_lsbs = ^drp_do[3:0];

  // DRP address of a given channel.
  function automatic logic [6:0] chan_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + 7'(i);
  endfunction

`ifdef VGA_SCHED_AVG_EN
  // Rounded mean of two samples. The sum is formed one bit wider, so the
  // carry is kept before the shift.
  function automatic logic [DATA_W-1:0] round_avg(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
    return sum[DATA_W:1];
  endfunction

  assign store_val = round_avg(shadow[idx], sample_p0);
`else
  assign store_val = sample_p0;
`endif

  assign drp_dwe    = 1'b0;
  assign idx_nxt    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign sweep_last = (state == NEXT) && (idx == LAST_IDX);

  // A publish happens only on a 0->1 edge of the registered vblank, and only
  // when a complete sweep is waiting to be shown.
  assign publish = vblnk_p0 && !vblnk_p1 && pending;

  // ---- Control FSM: DRP handshake, channel index, wait counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      drp_den     <= 1'b0;
      drp_daddr   <= BASE_ADDR;
      sweep_done  <= 1'b0;
      timeout_err <= '0;
    end else begin
      drp_den    <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= ISSUE;
            drp_den   <= 1'b1;
            drp_daddr <= chan_addr(idx);
          end
        end
        ISSUE: begin
          // drp_den was raised on entry, so it is high for this cycle only.
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // drdy takes priority, so a reply in the final counted cycle is
          // still accepted.
          if (drp_drdy) begin
            state <= STORE;
          end else if (wait_cnt == CNT_MAX) begin
            timeout_err[idx] <= 1'b1;
            state            <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STORE: begin
          state <= NEXT;
        end
        NEXT: begin
          idx <= idx_nxt;
          if (idx == LAST_IDX) begin
            sweep_done <= 1'b1;
          end
          if (enable) begin
            state     <= ISSUE;
            drp_den   <= 1'b1;
            drp_daddr <= chan_addr(idx_nxt);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- Capture stage: DRP sample into sample_p0, then into shadow ----
  // drdy is looked at only in WAIT. Stray or late replies never reach the
  // shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_p0 <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        shadow[n] <= '0;
      end
    end else begin
      if (state == WAIT && drp_drdy) begin
        sample_p0 <= drp_do[15:4];
      end
      if (state == WAIT && !drp_drdy && wait_cnt == CNT_MAX) begin
        shadow[idx] <= ERR_VAL;
      end else if (state == STORE) begin
        shadow[idx] <= store_val;
      end
    end
  end

  // ---- Publish stage: vblank edge detect, shadow -> display copy ----
  // The copy reads the shadow value from before this edge, so a write in the
  // same cycle is not included. When a sweep ends in the same cycle as a
  // publish, pending is set again so the new sweep is shown next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_p0     <= 1'b0;
      vblnk_p1     <= 1'b0;
      pending      <= 1'b0;
      frame_update <= 1'b0;
      disp_bank    <= '0;
    end else begin
      vblnk_p0     <= vblnk_in;
      vblnk_p1     <= vblnk_p0;
      frame_update <= 1'b0;
      if (publish) begin
        for (int n = 0; n < CHANNELS; n++) begin
          disp_bank[DATA_W*n +: DATA_W] <= shadow[n];
        end
        frame_update <= 1'b1;
        pending      <= 1'b0;
      end
      if (sweep_last) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
